// File: rtl/gate_activation.sv
// rtl/gate_activation.sv - LSTM gate activation: per-row Wx+Uh+bias then sigmoid/hard-tanh, one row per cycle
// Optional build macro GATE_PREACT_SAT_EN: saturate the pre-activation sum instead of wrapping it.
module gate_activation #(
   parameter int NROW     = 16,
   parameter int QN       = 6,
   parameter int QM       = 11,
   parameter int ACT_TYPE = 0,
   localparam int BITWIDTH = QN + QM + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dataReadyIn,
   input  logic [NROW*BITWIDTH-1:0] wxVector,
   input  logic [NROW*BITWIDTH-1:0] uhVector,
   input  logic [NROW*BITWIDTH-1:0] biasVector,
   output logic                     busy,
   output logic                     dataReadyOut,
   output logic [NROW*BITWIDTH-1:0] activVector
);

   localparam int IW = (NROW > 1) ? $clog2(NROW) : 1;
`ifdef GATE_PREACT_SAT_EN
   localparam int PREW = BITWIDTH + 2;
`else
   localparam int PREW = BITWIDTH;
`endif

   typedef logic signed [BITWIDTH-1:0] word_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam word_t                   ONE     = word_t'(2 ** QM);
   localparam word_t                   NEG_ONE = word_t'(-(2 ** QM));
   localparam logic signed [BITWIDTH:0] ONE_W  = (BITWIDTH + 1)'(2 ** QM);
   localparam logic signed [BITWIDTH:0] HALF_W = (BITWIDTH + 1)'(2 ** (QM - 1));
`ifdef GATE_PREACT_SAT_EN
   localparam logic signed [PREW-1:0]  SAT_HI  = PREW'(2 ** (BITWIDTH - 1) - 1);
   localparam logic signed [PREW-1:0]  SAT_LO  = PREW'(-(2 ** (BITWIDTH - 1)));
`endif

   state_t                   state_q;
   logic [IW-1:0]            idx_q;
   word_t                    wx_q   [NROW];
   word_t                    uh_q   [NROW];
   word_t                    bias_q [NROW];
   word_t                    act_q  [NROW];
   logic signed [PREW-1:0]   pre_q;
   logic                     pre_vld_q;
   logic [IW-1:0]            pre_row_q;
   logic                     busy_q;
   logic                     done_q;

   logic signed [PREW-1:0]   sum_d;
   word_t                    p_d;
   word_t                    y_d;
   logic signed [BITWIDTH:0] sig_d;

   // Size casts of signed operands sign-extend, so the sum cannot overflow in the saturating build.
   always_comb begin
      sum_d = PREW'(wx_q[idx_q]) + PREW'(uh_q[idx_q]) + PREW'(bias_q[idx_q]);
   end

   always_comb begin
`ifdef GATE_PREACT_SAT_EN
      if (pre_q > SAT_HI) begin
         p_d = word_t'(SAT_HI);
      end else if (pre_q < SAT_LO) begin
         p_d = word_t'(SAT_LO);
      end else begin
         p_d = pre_q[BITWIDTH-1:0];
      end
`else
      p_d = pre_q;
`endif
   end

   always_comb begin
      sig_d = (BITWIDTH + 1)'(p_d >>> 2) + HALF_W;
      y_d   = '0;
      if (ACT_TYPE == 0) begin
         if (sig_d < 0) begin
            y_d = '0;
         end else if (sig_d > ONE_W) begin
            y_d = ONE;
         end else begin
            y_d = word_t'(sig_d);
         end
      end else begin
         if (p_d > ONE) begin
            y_d = ONE;
         end else if (p_d < NEG_ONE) begin
            y_d = NEG_ONE;
         end else begin
            y_d = p_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pre_q     <= '0;
         pre_vld_q <= 1'b0;
         pre_row_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int r = 0; r < NROW; r++) begin
            wx_q[r]   <= '0;
            uh_q[r]   <= '0;
            bias_q[r] <= '0;
            act_q[r]  <= '0;
         end
      end else begin
         done_q    <= 1'b0;
         pre_vld_q <= 1'b0;
         if (pre_vld_q) begin
            act_q[pre_row_q] <= y_d;
         end
         case (state_q)
            S_IDLE: begin
               // busy stays up through the dataReadyOut cycle, which is already IDLE
               busy_q <= dataReadyIn;
               if (dataReadyIn) begin
                  for (int r = 0; r < NROW; r++) begin
                     wx_q[r]   <= wxVector[r*BITWIDTH +: BITWIDTH];
                     uh_q[r]   <= uhVector[r*BITWIDTH +: BITWIDTH];
                     bias_q[r] <= biasVector[r*BITWIDTH +: BITWIDTH];
                  end
                  idx_q   <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               pre_q     <= sum_d;
               pre_vld_q <= 1'b1;
               pre_row_q <= idx_q;
               if (idx_q == IW'(NROW - 1)) begin
                  state_q <= S_DRAIN;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            S_DRAIN: begin
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   for (genvar r = 0; r < NROW; r++) begin : g_pack
      assign activVector[r*BITWIDTH +: BITWIDTH] = act_q[r];
   end

   assign busy         = busy_q;
   assign dataReadyOut = done_q;

endmodule

// File: tb/tb_gate_activation.sv
// tb/tb_gate_activation.sv - scoreboard bench for gate_activation, sigmoid and tanh instances side by side
module tb_gate_activation;
   localparam int NROW = 16;
   localparam int QN   = 6;
   localparam int QM   = 11;
   localparam int BW   = QN + QM + 1;
   localparam int VW   = NROW * BW;
   localparam int LAT  = NROW + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          dri = 1'b0;
   logic [VW-1:0] wx_v = '0;
   logic [VW-1:0] uh_v = '0;
   logic [VW-1:0] b_v = '0;
   logic          busy_s, dro_s, busy_t, dro_t;
   logic [VW-1:0] act_s, act_t;

   gate_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(0)) dut_sig (
      .clk(clk), .reset(reset), .dataReadyIn(dri), .wxVector(wx_v), .uhVector(uh_v),
      .biasVector(b_v), .busy(busy_s), .dataReadyOut(dro_s), .activVector(act_s));

   gate_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(1)) dut_tanh (
      .clk(clk), .reset(reset), .dataReadyIn(dri), .wxVector(wx_v), .uhVector(uh_v),
      .biasVector(b_v), .busy(busy_t), .dataReadyOut(dro_t), .activVector(act_t));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [VW-1:0] exp_s_q[$];
   logic [VW-1:0] exp_t_q[$];
   int            exp_cyc_q[$];

   int twx[NROW];
   int tuh[NROW];
   int tb_b[NROW];

   function automatic void chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void cmp_vec(input string name, input logic [VW-1:0] a, input logic [VW-1:0] e);
      int bad;
      bad = -1;
      for (int r = NROW - 1; r >= 0; r--)
         if (a[r*BW +: BW] !== e[r*BW +: BW]) bad = r;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0d required=%0d (cycle %0d)", name, bad,
                  $signed(a[bad*BW +: BW]), $signed(e[bad*BW +: BW]), cyc);
      end
   endfunction

   // Reference: the fixed-point rules worked in plain integer arithmetic.
   function automatic int model(input int wx, input int uh, input int b, input int typ);
      int s, p, y, half_rng, one;
      half_rng = 1 << (BW - 1);
      one = 1 << QM;
      s = wx + uh + b;
`ifdef GATE_PREACT_SAT_EN
      p = (s > half_rng - 1) ? half_rng - 1 : ((s < -half_rng) ? -half_rng : s);
`else
      p = ((s % (2 * half_rng)) + 2 * half_rng) % (2 * half_rng);
      if (p >= half_rng) p = p - 2 * half_rng;
`endif
      if (typ == 0) begin
         y = (p >>> 2) + one / 2;
         if (y < 0) y = 0;
         if (y > one) y = one;
      end else begin
         y = p;
         if (y > one) y = one;
         if (y < -one) y = -one;
      end
      return y;
   endfunction

   task automatic load_inputs();
      for (int r = 0; r < NROW; r++) begin
         wx_v[r*BW +: BW] = BW'(twx[r]);
         uh_v[r*BW +: BW] = BW'(tuh[r]);
         b_v[r*BW +: BW]  = BW'(tb_b[r]);
      end
   endtask

   // Returns at the falling edge right after the capture edge (cyc == cap there).
   task automatic issue(output int cap);
      logic [VW-1:0] es, et;
      @(negedge clk);
      load_inputs();
      for (int r = 0; r < NROW; r++) begin
         es[r*BW +: BW] = BW'(model(twx[r], tuh[r], tb_b[r], 0));
         et[r*BW +: BW] = BW'(model(twx[r], tuh[r], tb_b[r], 1));
      end
      dri = 1'b1;
      cap = cyc + 1;
      exp_s_q.push_back(es);
      exp_t_q.push_back(et);
      exp_cyc_q.push_back(cap + LAT);
      @(negedge clk);
      dri = 1'b0;
      chk(busy_s && busy_t, "busy_after_capture", int'(busy_s & busy_t), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_cyc_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(exp_cyc_q.size() == 0, "done_timeout", exp_cyc_q.size(), 0);
      exp_cyc_q.delete();
      exp_s_q.delete();
      exp_t_q.delete();
      @(negedge clk);
      chk(!busy_s && !busy_t, "busy_after_done", int'(busy_s | busy_t), 0);
   endtask

   task automatic fill_const(input int wx, input int uh, input int b);
      for (int r = 0; r < NROW; r++) begin
         twx[r] = wx;
         tuh[r] = uh;
         tb_b[r] = b;
      end
   endtask

   function automatic int rnd_val(input int mode);
      case (mode)
         0:       return int'($urandom_range(0, 262143)) - 131072;
         1:       return int'($urandom_range(0, 16384)) - 8192;
         2:       return int'($urandom_range(0, 4096)) - 2048;
         default: return int'($urandom_range(0, 64)) - 32;
      endcase
   endfunction

   task automatic fill_rand();
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int r = 0; r < NROW; r++) begin
         twx[r] = rnd_val(mode);
         tuh[r] = rnd_val(mode);
         tb_b[r] = rnd_val(mode);
      end
   endtask

   // Monitor: pops one expectation per dataReadyOut pulse.
   int            m_cyc;
   logic [VW-1:0] m_s, m_t;
   always @(negedge clk) begin
      if (!reset && (dro_s || dro_t)) begin
         if (exp_cyc_q.size() == 0) begin
            chk(1'b0, "unexpected_dataReadyOut", 1, 0);
         end else begin
            m_cyc = exp_cyc_q.pop_front();
            m_s = exp_s_q.pop_front();
            m_t = exp_t_q.pop_front();
            chk(cyc == m_cyc, "latency_cycle", cyc, m_cyc);
            chk(dro_s && dro_t, "dro_both", int'(dro_s & dro_t), 1);
            chk(busy_s && busy_t, "busy_at_done", int'(busy_s & busy_t), 1);
            cmp_vec("sigmoid_vec", act_s, m_s);
            cmp_vec("tanh_vec", act_t, m_t);
         end
      end
   end

   int cap;
   initial begin
      // Reset held 3 cycles with dataReadyIn asserted.
      fill_rand();
      load_inputs();
      reset = 1'b1;
      dri = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk(act_s == '0 && act_t == '0, "reset_act", 0, 0);
         chk(!busy_s && !busy_t && !dro_s && !dro_t, "reset_ctrl",
             int'({busy_s, busy_t, dro_s, dro_t}), 0);
      end
      dri = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk(!busy_s && !dro_s && act_s == '0, "post_reset_idle", int'(busy_s), 0);

      // x = 1.0 on every row.
      fill_const(2048, 0, 0);
      issue(cap);
      wait_idle();
      chk($signed(act_s[0 +: BW]) == 1536, "sig_x1_row0", $signed(act_s[0 +: BW]), 1536);
      chk($signed(act_t[0 +: BW]) == 2048, "tanh_x1_row0", $signed(act_t[0 +: BW]), 2048);

      // Clamp rows: +8192, -8192, 0.
      for (int r = 0; r < NROW; r++) begin
         twx[r] = (r % 3 == 0) ? 8192 : ((r % 3 == 1) ? -8192 : 0);
         tuh[r] = 0;
         tb_b[r] = 0;
      end
      issue(cap);
      wait_idle();
      chk($signed(act_s[0*BW +: BW]) == 2048, "sig_clamp_hi", $signed(act_s[0*BW +: BW]), 2048);
      chk($signed(act_s[1*BW +: BW]) == 0, "sig_clamp_lo", $signed(act_s[1*BW +: BW]), 0);
      chk($signed(act_s[2*BW +: BW]) == 1024, "sig_zero", $signed(act_s[2*BW +: BW]), 1024);

      // Tanh linear region and rails.
      for (int r = 0; r < NROW; r++) begin
         twx[r] = (r < 8) ? 1024 : ((r % 2 == 0) ? 4096 : -4096);
         tuh[r] = (r < 8) ? 512 : 0;
         tb_b[r] = (r < 8) ? -256 : 0;
      end
      issue(cap);
      wait_idle();
      chk($signed(act_t[0*BW +: BW]) == 1280, "tanh_lin", $signed(act_t[0*BW +: BW]), 1280);
      chk($signed(act_t[8*BW +: BW]) == 2048, "tanh_pos", $signed(act_t[8*BW +: BW]), 2048);
      chk($signed(act_t[9*BW +: BW]) == -2048, "tanh_neg", $signed(act_t[9*BW +: BW]), -2048);

      // Pre-activation overflow.
      fill_const(131071, 131071, 0);
      issue(cap);
      wait_idle();
`ifdef GATE_PREACT_SAT_EN
      chk($signed(act_s[5*BW +: BW]) == 2048, "sig_overflow", $signed(act_s[5*BW +: BW]), 2048);
`else
      chk($signed(act_s[5*BW +: BW]) == 1023, "sig_overflow", $signed(act_s[5*BW +: BW]), 1023);
`endif

      // Retrigger at T+5 with other data must be ignored.
      fill_const(1000, 200, -100);
      issue(cap);
      while (cyc < cap + 4) @(negedge clk);
      fill_const(-3000, 7, 55);
      load_inputs();
      dri = 1'b1;
      @(negedge clk);
      dri = 1'b0;
      wait_idle();

      // Back-to-back at the earliest accepted edge, T+NROW+3.
      fill_rand();
      issue(cap);
      while (cyc < cap + NROW + 1) @(negedge clk);
      fill_rand();
      issue(cap);
      chk(cap == exp_cyc_q[0] - LAT, "b2b_capture", cap, exp_cyc_q[0] - LAT);
      wait_idle();

      // Randomized runs with random spacing.
      for (int k = 0; k < 12; k++) begin
         fill_rand();
         issue(cap);
         wait_idle();
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
      end

      // Reset asserted so that it is sampled at T+8.
      fill_const(4000, 0, 0);
      issue(cap);
      while (cyc < cap + 7) @(negedge clk);
      reset = 1'b1;
      exp_cyc_q.delete();
      exp_s_q.delete();
      exp_t_q.delete();
      @(negedge clk);
      chk(act_s == '0 && act_t == '0, "midrun_reset_act", 0, 0);
      chk(!busy_s && !busy_t && !dro_s && !dro_t, "midrun_reset_ctrl",
          int'({busy_s, busy_t, dro_s, dro_t}), 0);
      reset = 1'b0;
      repeat (NROW + 6) @(negedge clk);
      chk(act_s == '0 && act_t == '0, "after_abort_act", 0, 0);
      chk(!busy_s && !busy_t, "after_abort_busy", int'(busy_s | busy_t), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0d required=0", cyc);
      $fatal(1, "timeout");
   end

endmodule
